dac_spi_writer: RTL and testbench

//  Transmit-side counterpart of the ADC capture path: pushes four 12-bit channel values to an

---
 rtl/dac_spi_writer.sv | 203 ++++++++++++++++++++
 tb/tb_dac_spi_writer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/dac_spi_writer.sv
// dac_spi_writer
//   Drives a quad 12-bit SPI DAC (mode 0, 16-bit frames, MSB first). It keeps a
//   shadow of the last code sent on each channel and transmits only channels whose
//   input differs from that shadow, or which have been force-marked. Channels are
//   serviced round-robin, starting after the channel sent last.
//   Frame word: {addr[1:0], cmd[1:0] = 2'b01 (write + update), data[11:0]}.
// Parameters
//   CLK_DIV      SCK half-period in clk cycles (>= 1)
//   CS_HIGH_MIN  clk cycles DAC_CS_N stays high between frames (>= 1)
// Ports
//   clk, rst_n         clock; asynchronous active-low reset
//   enable             allow new frames to start (a frame in progress always completes)
//   refresh_req        1-cycle pulse: mark all four channels dirty
//   ch0..ch3           requested 12-bit DAC code per channel
//   DAC_CS_N/SCK/SDI   registered SPI pins
//   busy               high for the whole frame, from LOAD to frame_done inclusive
//   frame_done         1-cycle pulse in the last cycle of each frame
//   cur_ch             channel of the frame in progress, or of the last frame sent
module dac_spi_writer #(
  parameter int CLK_DIV     = 2,
  parameter int CS_HIGH_MIN = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        refresh_req,
  input  logic [11:0] ch0,
  input  logic [11:0] ch1,
  input  logic [11:0] ch2,
  input  logic [11:0] ch3,
  output logic        DAC_CS_N,
  output logic        DAC_SCK,
  output logic        DAC_SDI,
  output logic        busy,
  output logic        frame_done,
  output logic [1:0]  cur_ch
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SHIFT, S_TAIL, S_CSHI} state_t;

  localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
  localparam logic [15:0] CSHI_LAST = 16'(CS_HIGH_MIN - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;      // clk cycles within the current phase
  logic [4:0]  half_q, half_d;    // SCK half-period index: even = low, odd = high
  logic [15:0] word_q, word_d;
  logic [11:0] shadow_q [4];
  logic [11:0] shadow_d [4];
  logic [3:0]  force_q, force_d;
  logic [1:0]  cur_ch_q, cur_ch_d;
  logic        cs_n_q, cs_n_d;
  logic        sck_q, sck_d;
  logic        sdi_q, sdi_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic [11:0] ch_in [4];
  logic [3:0]  dirty;
  logic [1:0]  sel;
  logic        found;

  assign ch_in[0] = ch0;
  assign ch_in[1] = ch1;
  assign ch_in[2] = ch2;
  assign ch_in[3] = ch3;

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      dirty[i] = force_q[i] | (ch_in[i] != shadow_q[i]);
    end
  end

  // Round-robin pick: search cur_ch+1, +2, +3, then cur_ch itself.
  always_comb begin
    logic [1:0] cand;
    sel   = cur_ch_q;
    found = 1'b0;
    cand  = cur_ch_q;
    for (int k = 1; k <= 4; k++) begin
      cand = cur_ch_q + 2'(k);
      if (!found && dirty[cand]) begin
        sel   = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    half_d   = half_q;
    word_d   = word_q;
    shadow_d = shadow_q;
    force_d  = force_q;
    cur_ch_d = cur_ch_q;

    case (state_q)
      S_IDLE: begin
        if (enable && found) begin
          state_d  = S_LOAD;
          cur_ch_d = sel;
        end
      end
      S_LOAD: begin
        // The data is taken from the input during LOAD; it is what the shadow records.
        word_d                = {cur_ch_q, 2'b01, ch_in[cur_ch_q]};
        shadow_d[cur_ch_q]    = ch_in[cur_ch_q];
        force_d[cur_ch_q]     = 1'b0;
        state_d               = S_SHIFT;
        cnt_d                 = '0;
        half_d                = '0;
      end
      S_SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (half_q == 5'd31) begin
            state_d = S_TAIL;
          end else begin
            half_d = half_q + 5'd1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_TAIL: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d   = '0;
          state_d = S_CSHI;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_CSHI: begin
        if (cnt_q == CSHI_LAST) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Applied after the LOAD clear so a coincident request leaves the channel forced.
    if (refresh_req) begin
      force_d = 4'hF;
    end
  end

  // Pin values are derived from the next state so the registered pins line up
  // with state_q; nothing reaches the pins combinationally.
  always_comb begin
    cs_n_d = !(state_d == S_LOAD || state_d == S_SHIFT || state_d == S_TAIL);
    sck_d  = (state_d == S_SHIFT) && half_d[0];
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_CSHI) && (cnt_d == CSHI_LAST);
    case (state_d)
      S_LOAD:  sdi_d = cur_ch_d[1];                   // bit 15 is addr[1]
      S_SHIFT: sdi_d = word_d[4'd15 - half_d[4:1]];   // advances only on a low phase
      S_TAIL:  sdi_d = sdi_q;
      default: sdi_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      half_q   <= '0;
      word_q   <= '0;
      shadow_q <= '{default: '0};
      force_q  <= 4'hF;
      cur_ch_q <= 2'd3;
      cs_n_q   <= 1'b1;
      sck_q    <= 1'b0;
      sdi_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      half_q   <= half_d;
      word_q   <= word_d;
      shadow_q <= shadow_d;
      force_q  <= force_d;
      cur_ch_q <= cur_ch_d;
      cs_n_q   <= cs_n_d;
      sck_q    <= sck_d;
      sdi_q    <= sdi_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign DAC_CS_N   = cs_n_q;
  assign DAC_SCK    = sck_q;
  assign DAC_SDI    = sdi_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign cur_ch     = cur_ch_q;

endmodule

// File: tb/tb_dac_spi_writer.sv
// Testbench for dac_spi_writer (default parameters). Stimulus pushes the expected
// SPI words into a queue; a monitor decodes frames from the pins and compares.
module tb_dac_spi_writer;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b1;
  logic        refresh_req = 1'b0;
  logic [11:0] ch0 = '0, ch1 = '0, ch2 = '0, ch3 = '0;
  logic        DAC_CS_N, DAC_SCK, DAC_SDI, busy, frame_done;
  logic [1:0]  cur_ch;

  int vectors = 0;
  int errors  = 0;
  logic [15:0] exp_q [$];

  dac_spi_writer #(.CLK_DIV(2), .CS_HIGH_MIN(4)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .refresh_req(refresh_req),
    .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3),
    .DAC_CS_N(DAC_CS_N), .DAC_SCK(DAC_SCK), .DAC_SDI(DAC_SDI),
    .busy(busy), .frame_done(frame_done), .cur_ch(cur_ch)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Frame monitor: shifts SDI on each SCK rise while CS_N is low; compares on CS_N rise.
  initial begin
    logic [15:0] bits;
    int          nbits;
    logic        in_frame, prev_cs, prev_sck;
    bits = '0; nbits = 0; in_frame = 1'b0; prev_cs = 1'b1; prev_sck = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        nbits = 0; in_frame = 1'b0;
      end else begin
        if (prev_cs && !DAC_CS_N) begin
          nbits = 0; in_frame = 1'b1;
        end
        if (!DAC_CS_N && DAC_SCK && !prev_sck) begin
          bits = {bits[14:0], DAC_SDI};
          nbits++;
        end
        if (!prev_cs && DAC_CS_N && in_frame) begin
          in_frame = 1'b0;
          if (exp_q.size() == 0) begin
            check("unexpected_frame", int'(bits), -1);
          end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            check("frame_word", int'(bits), int'(e));
            check("frame_sck_rises", nbits, 16);
          end
        end
      end
      prev_cs  = DAC_CS_N;
      prev_sck = DAC_SCK;
    end
  end

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) check({name, "_timeout"}, exp_q.size(), 0);
  endtask

  task automatic wait_busy(input string name);
    int n;
    n = 0;
    while (!busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check({name, "_no_busy"}, 0, 1);
  endtask

  task automatic quiet(input string name, input int cycles);
    int lows;
    lows = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (!DAC_CS_N || busy) lows++;
    end
    check(name, lows, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, fd_at, fd_cnt, rises;
    logic prev;

    // 1: reset state, then init sequence of all four channels with data 0
    repeat (3) @(negedge clk);
    check("reset_state", int'({DAC_CS_N, DAC_SCK, DAC_SDI, busy, frame_done, cur_ch}), 'b1000011);
    exp_q.push_back(16'h1000); exp_q.push_back(16'h5000);
    exp_q.push_back(16'h9000); exp_q.push_back(16'hD000);
    rst_n = 1'b1;
    drain("init");
    quiet("idle_after_init", 100);

    // 2: single channel change, frame length and frame_done position
    ch2 = 12'hABC;
    exp_q.push_back(16'h9ABC);
    wait_busy("t2");
    n = 0; fd_at = 0; fd_cnt = 0;
    while (busy && n < 500) begin
      n++;
      if (frame_done) begin fd_cnt++; fd_at = n; end
      @(negedge clk);
    end
    check("busy_cycles", n, 71);
    check("frame_done_cycle", fd_at, 71);
    check("frame_done_pulses", fd_cnt, 1);
    drain("t2");

    // 3: round-robin order from cur_ch=1
    ch1 = 12'h111;
    exp_q.push_back(16'h5111);
    drain("t3a");
    check("cur_ch_before_rr", int'(cur_ch), 1);
    ch0 = 12'h222; ch1 = 12'h333; ch3 = 12'h444;
    exp_q.push_back(16'hD444); exp_q.push_back(16'h1222); exp_q.push_back(16'h5333);
    drain("t3b");

    // 4: input change mid-frame; ch1 write of 0x200 is {01,01,0x200} = 0x5200
    ch1 = 12'h100;
    exp_q.push_back(16'h5100);
    wait_busy("t4");
    repeat (20) @(negedge clk);
    ch1 = 12'h200;
    exp_q.push_back(16'h5200);
    drain("t4");

    // 5: asynchronous reset during bit 7 of a frame
    ch0 = 12'h0F0;
    wait_busy("t5");
    rises = 0; n = 0; prev = DAC_SCK;
    while (rises < 8 && n < 200) begin
      @(negedge clk);
      if (DAC_SCK && !prev) rises++;
      prev = DAC_SCK;
      n++;
    end
    #2 rst_n = 1'b0;
    #1 check("async_reset_pins", int'({DAC_CS_N, DAC_SCK}), 'b10);
    exp_q.delete();
    exp_q.push_back(16'h10F0); exp_q.push_back(16'h5200);
    exp_q.push_back(16'h9ABC); exp_q.push_back(16'hD444);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drain("t5");

    // 6: enable low holds pending changes; then refresh resends everything
    enable = 1'b0;
    ch0 = 12'h456; ch2 = 12'h123;
    quiet("disabled_quiet", 100);
    exp_q.push_back(16'h1456); exp_q.push_back(16'h9123);
    enable = 1'b1;
    drain("t6a");
    check("cur_ch_after_pending", int'(cur_ch), 2);
    exp_q.push_back(16'hD444); exp_q.push_back(16'h1456);
    exp_q.push_back(16'h5200); exp_q.push_back(16'h9123);
    refresh_req = 1'b1;
    @(negedge clk);
    refresh_req = 1'b0;
    drain("t6b");
    quiet("idle_at_end", 50);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
